// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the AXI3 memory arbiter.
//   rd_state_e : read channel FSM states (AR/R)
//   wr_state_e : write channel FSM states (AW/W/B)
//   burst, size and default ID encodings used on the AXI master port
package mem_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [2:0] SIZE_1B     = 3'b000;
    localparam logic [2:0] SIZE_2B     = 3'b001;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    localparam logic [3:0] DEF_INST_ID = 4'd0;
    localparam logic [3:0] DEF_DATA_ID = 4'd1;

endpackage

// File: rtl/axi_mem_arbiter.sv
// Merges instruction-fetch reads, data reads and data writes onto one AXI3
// master port. Reads and writes run on independent FSMs; one read and one
// write may be outstanding at the same time.
//
// Ports:
//   aclk, aresetn        clock, synchronous active-low reset
//   ir_*                 instruction read request / returned beats
//   dr_*                 data read request / returned beats
//   dw_*                 data write request; dw_beat advances requester data,
//                        dw_done pulses the cycle after the B handshake
//   ar*/r*/aw*/w*/b*     AXI3 master channels
//
// Read FSM
//   state  | meaning
//   R_IDLE | choose dr (only while writes idle) over ir, latch request
//   R_ADDR | drive AR with latched fields until arready
//   R_DATA | steer R beats to the owner by latched id until rlast
//
// Write FSM
//   state  | meaning
//   W_IDLE | accept dw request, latch addr/len/size
//   W_ADDR | drive AW until awready
//   W_DATA | stream requester beats, wlast on beat len
//   W_RESP | wait for bvalid, then pulse dw_done
module axi_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [3:0] INST_ID = DEF_INST_ID,
    parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
    input  logic        aclk,
    input  logic        aresetn,

    input  logic        ir_valid,
    output logic        ir_ready,
    input  logic [31:0] ir_addr,
    input  logic [7:0]  ir_len,
    output logic [31:0] ir_rdata,
    output logic        ir_rvalid,
    output logic        ir_rlast,

    input  logic        dr_valid,
    output logic        dr_ready,
    input  logic [31:0] dr_addr,
    input  logic [7:0]  dr_len,
    input  logic [2:0]  dr_size,
    output logic [31:0] dr_rdata,
    output logic        dr_rvalid,
    output logic        dr_rlast,

    input  logic        dw_valid,
    output logic        dw_ready,
    input  logic [31:0] dw_addr,
    input  logic [7:0]  dw_len,
    input  logic [2:0]  dw_size,
    input  logic [31:0] dw_wdata,
    input  logic [3:0]  dw_wstrb,
    output logic        dw_beat,
    output logic        dw_done,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    rd_state_e   r_state_q, r_state_d;
    logic [31:0] ar_addr_q, ar_addr_d;
    logic [7:0]  ar_len_q,  ar_len_d;
    logic [2:0]  ar_size_q, ar_size_d;
    logic [3:0]  ar_id_q,   ar_id_d;

    wr_state_e   w_state_q, w_state_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic [7:0]  aw_len_q,  aw_len_d;
    logic [2:0]  aw_size_q, aw_size_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;
    logic        dw_done_q, dw_done_d;

    logic        rd_to_inst;
    logic        rd_to_data;

    // Response IDs and responses are not needed: only one transaction per
    // direction is ever outstanding.
    logic        unused_axi;
    assign unused_axi = ^{rid, rresp, bid, bresp};

    // ---------------------------------------------------------------- read
    always_comb begin
        r_state_d = r_state_q;
        ar_addr_d = ar_addr_q;
        ar_len_d  = ar_len_q;
        ar_size_d = ar_size_q;
        ar_id_d   = ar_id_q;
        ir_ready  = 1'b0;
        dr_ready  = 1'b0;
        arvalid   = 1'b0;
        rready    = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                // Ready is gated by reset so no request is acknowledged
                // (and then lost) on a reset edge.
                if (aresetn) begin
                    if (dr_valid && (w_state_q == W_IDLE)) begin
                        dr_ready  = 1'b1;
                        ar_addr_d = dr_addr;
                        ar_len_d  = dr_len;
                        ar_size_d = dr_size;
                        ar_id_d   = DATA_ID;
                        r_state_d = R_ADDR;
                    end else if (ir_valid) begin
                        ir_ready  = 1'b1;
                        ar_addr_d = ir_addr;
                        ar_len_d  = ir_len;
                        ar_size_d = SIZE_4B;
                        ar_id_d   = INST_ID;
                        r_state_d = R_ADDR;
                    end
                end
            end
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid && rlast) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign arid    = ar_id_q;
    assign araddr  = ar_addr_q;
    assign arlen   = ar_len_q;
    assign arsize  = ar_size_q;
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign rd_to_inst = (r_state_q == R_DATA) && (ar_id_q == INST_ID);
    assign rd_to_data = (r_state_q == R_DATA) && (ar_id_q != INST_ID);

    assign ir_rdata  = rdata;
    assign ir_rvalid = rd_to_inst && rvalid;
    assign ir_rlast  = rd_to_inst && rlast;
    assign dr_rdata  = rdata;
    assign dr_rvalid = rd_to_data && rvalid;
    assign dr_rlast  = rd_to_data && rlast;

    // --------------------------------------------------------------- write
    always_comb begin
        w_state_d  = w_state_q;
        aw_addr_d  = aw_addr_q;
        aw_len_d   = aw_len_q;
        aw_size_d  = aw_size_q;
        beat_cnt_d = beat_cnt_q;
        dw_done_d  = 1'b0;
        dw_ready   = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        dw_beat    = 1'b0;
        bready     = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                if (aresetn && dw_valid) begin
                    dw_ready  = 1'b1;
                    aw_addr_d = dw_addr;
                    aw_len_d  = dw_len;
                    aw_size_d = dw_size;
                    w_state_d = W_ADDR;
                end
            end
            W_ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    beat_cnt_d = 8'd0;
                    w_state_d  = W_DATA;
                end
            end
            W_DATA: begin
                wvalid = 1'b1;
                wlast  = (beat_cnt_q == aw_len_q);
                if (wready) begin
                    dw_beat    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (wlast) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    dw_done_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awid    = DATA_ID;
    assign awaddr  = aw_addr_q;
    assign awlen   = aw_len_q;
    assign awsize  = aw_size_q;
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = DATA_ID;
    assign wdata   = dw_wdata;
    assign wstrb   = dw_wstrb;

    // Registered so the pulse lands in the first W_IDLE cycle, the same
    // cycle a waiting data read becomes eligible.
    assign dw_done = dw_done_q;

    // ----------------------------------------------------------- registers
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= 32'd0;
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_id_q    <= 4'd0;
            w_state_q  <= W_IDLE;
            aw_addr_q  <= 32'd0;
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            beat_cnt_q <= 8'd0;
            dw_done_q  <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_id_q    <= ar_id_d;
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            beat_cnt_q <= beat_cnt_d;
            dw_done_q  <= dw_done_d;
        end
    end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Sits between the cache/MMU request side and the single AXI3 master port of the CPU top level.
- Merges three requesters onto one AXI port: instruction-fetch reads, data reads and data writes. Requests arrive as cache line refills, cache line writebacks or uncached single accesses.
- Owns all AR/R/AW/W/B channel sequencing.
- Reads and writes run on independent state machines.

Parameters:
- INST_ID, 4'd0, arid/rid value used for instruction reads.
- DATA_ID, 4'd1, arid/awid/wid/rid value used for data traffic.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset: one clock, synchronous, active-low
- ir_valid/ir_ready  in/out  1/1  instruction read request handshake
- ir_addr  in  32  instruction read start address
- ir_len  in  8  instruction read length, beats-1
- ir_rdata  out  32  instruction read returned data
- ir_rvalid  out  1  instruction read data beat valid
- ir_rlast  out  1  last instruction read beat
- dr_valid/dr_ready  in/out  1/1  data read request handshake
- dr_addr  in  32  data read start address
- dr_len  in  8  data read length, beats-1
- dr_size  in  3  data read beat size
- dr_rdata  out  32  data read returned data
- dr_rvalid  out  1  data read beat valid
- dr_rlast  out  1  last data read beat
- dw_valid/dw_ready  in/out  1/1  data write request handshake
- dw_addr  in  32  write start address
- dw_len  in  8  write length, beats-1
- dw_size  in  3  write beat size
- dw_wdata  in  32  write beat data, presented by the requester
- dw_wstrb  in  4  write beat strobes
- dw_beat  out  1  current write beat consumed; requester advances data
- dw_done  out  1  one-cycle pulse when the B response is accepted
- AXI3 master  ar*/r*/aw*/w*/b*  standard widths (arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, and the AW equivalents); mirrors the CPU top-level AXI port list

Behaviour:
- Reset (aresetn low at a rising edge):
  - Both FSMs go to IDLE.
  - arvalid, awvalid, wvalid, rready, bready, every *_ready, *_rvalid, dw_beat and dw_done are 0.
  - The beat counter is 0.
  - Reset mid-burst abandons the transaction with no completion pulse; the whole SoC resets together.
- Constant outputs:
  - arburst/awburst = 2'b01 (INCR).
  - arlock, awlock, arcache, awcache, arprot, awprot = 0.
  - awid = wid = DATA_ID.
- Read FSM states: R_IDLE -> R_ADDR -> R_DATA -> R_IDLE.
  - R_IDLE: select a requester and latch its addr/len/size/id. Assert that requester's *_ready for exactly 1 cycle, then go to R_ADDR.
  - Selection: dr_valid has priority over ir_valid.
  - dr is eligible only while the write FSM is in W_IDLE (read-after-write ordering); ir is never blocked.
  - Instruction reads use arsize = 3'b010.
  - R_ADDR: arvalid = 1 with the latched fields. Hold all AR signals stable until arready. On arvalid&&arready go to R_DATA.
  - R_DATA: rready = 1. Each rvalid beat is steered by the latched id to ir_* or dr_*, with *_rvalid = rvalid and *_rlast = rlast, combinationally, zero added latency.
  - rlast&&rvalid -> R_IDLE.
  - One read outstanding at a time.
  - rresp is ignored.
- Write FSM states: W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: on dw_valid, latch addr/len/size, pulse dw_ready for 1 cycle, go to W_ADDR.
  - W_ADDR: awvalid = 1. On awready go to W_DATA and clear the beat counter.
  - W_DATA: wvalid = 1, wdata = dw_wdata, wstrb = dw_wstrb, wlast = (counter == latched len).
    - On wvalid&&wready: dw_beat = 1 and the counter increments. If wlast, go to W_RESP.
    - The counter is 8 bits; len = 0 gives a single beat with wlast = 1.
  - W_RESP: bready = 1. On bvalid pulse dw_done and go to W_IDLE.
  - bresp is ignored.
- Concurrency:
  - Read and write FSMs operate simultaneously on independent channels.
  - A dr request arriving while a write is active waits in R_IDLE until W_IDLE, then wins over a pending ir.
- Stalls: arready/awready/wready may stay low indefinitely. Outputs must hold stable, with no request loss or duplication.

Decomposition:
- Shared package mem_arb_pkg:
  - Read state enum and write state enum.
  - INCR burst encoding, size encodings, default ID constants.
- No sub-module: the two FSMs plus the R-channel steering fit in one module of about 250 lines.

Test Plan:
- ir_addr=0x1FC00000, ir_len=7 alone, rvalid every cycle:
  - araddr=0x1FC00000, arlen=7, arid=0.
  - 8 ir_rvalid beats, ir_rlast on beat 8.
  - dr_rvalid stays 0.
- ir_valid and dr_valid (dr_addr=0x80001000) asserted in the same cycle:
  - dr_ready first, first AR has arid=1.
  - The instruction AR is issued only after the data rlast.
- Write 0x80002000, len=7, wready toggling 1/0:
  - 8 dw_beat pulses; wlast only on the 8th handshake.
  - awvalid held until awready.
  - dw_done one cycle after bvalid.
- Write pending (bvalid delayed 20 cycles) plus a dr request:
  - arvalid stays 0 until the cycle after dw_done.
  - A concurrent ir request proceeds during the wait.
- aresetn driven low during beat 3 of a read burst:
  - The next edge gives arvalid=0, rready=0, FSM in R_IDLE.
  - A new ir request after release is served normally.
- Uncached single write, dw_len=0, dw_size=3'b000, wstrb=4'b0010:
  - awlen=0, awsize=0.
  - One beat with wlast=1.
